// File: rtl/ex_issue_stage_pkg.sv
// Shared widths, register-zero constant, slot record and ALU opcodes for the operand issue stage.
package ex_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned OP_W   = 4;
   localparam int unsigned REG_W  = 3;

   localparam logic [REG_W-1:0] REG_ZERO = '0;

   typedef enum logic [OP_W-1:0] {
      OP_ADD   = 4'h0,
      OP_SUB   = 4'h1,
      OP_AND   = 4'h2,
      OP_OR    = 4'h3,
      OP_XOR   = 4'h4,
      OP_NOT   = 4'h5,
      OP_SLT   = 4'h6,
      OP_SLTU  = 4'h7,
      OP_MOV   = 4'h8,
      OP_PASSB = 4'h9,
      OP_SRA   = 4'hA,
      OP_SRL   = 4'hB,
      OP_SHL   = 4'hC
   } ex_alu_op_e;

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [REG_W-1:0]  rd;
      logic              wr_en;
      logic [REG_W-1:0]  ra;
      logic [REG_W-1:0]  rb;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic              use_imm;
   } ex_slot_t;

endpackage

// File: rtl/ex_issue_stage_if.sv
// Decode, writeback and execute-side signals of the issue stage; slave is the stage's own view.
interface ex_issue_if #(
   parameter int unsigned DATA_W = ex_pkg::DATA_W,
   parameter int unsigned OP_W   = ex_pkg::OP_W,
   parameter int unsigned REG_W  = ex_pkg::REG_W
);
   logic              flush;

   logic              id_valid;
   logic              id_ready;
   logic [OP_W-1:0]   id_op;
   logic [REG_W-1:0]  id_rd;
   logic              id_wr_en;
   logic [REG_W-1:0]  id_ra;
   logic [REG_W-1:0]  id_rb;
   logic [DATA_W-1:0] id_a;
   logic [DATA_W-1:0] id_b;
   logic [DATA_W-1:0] id_imm;
   logic              id_use_imm;

   logic              wb_valid;
   logic [REG_W-1:0]  wb_rd;
   logic [DATA_W-1:0] wb_data;

   logic              ex_valid;
   logic              ex_ready;
   logic [OP_W-1:0]   ex_op;
   logic [DATA_W-1:0] ex_a;
   logic [DATA_W-1:0] ex_b;
   logic [REG_W-1:0]  ex_rd;
   logic              ex_wr_en;

   modport slave (
      input  flush,
      input  id_valid, id_op, id_rd, id_wr_en, id_ra, id_rb, id_a, id_b, id_imm, id_use_imm,
      output id_ready,
      input  wb_valid, wb_rd, wb_data,
      output ex_valid, ex_op, ex_a, ex_b, ex_rd, ex_wr_en,
      input  ex_ready
   );

   modport master (
      output flush,
      output id_valid, id_op, id_rd, id_wr_en, id_ra, id_rb, id_a, id_b, id_imm, id_use_imm,
      input  id_ready,
      output wb_valid, wb_rd, wb_data,
      input  ex_valid, ex_op, ex_a, ex_b, ex_rd, ex_wr_en,
      output ex_ready
   );

endinterface

// File: rtl/ex_operand_snoop.sv
// Combinational compare-and-replace of one operand against the writeback bus.
module ex_operand_snoop #(
   parameter int unsigned DATA_W = ex_pkg::DATA_W,
   parameter int unsigned REG_W  = ex_pkg::REG_W
) (
   input  logic              i_fwd_en,
   input  logic [REG_W-1:0]  i_reg,
   input  logic [DATA_W-1:0] i_val,
   input  logic              i_wb_valid,
   input  logic [REG_W-1:0]  i_wb_rd,
   input  logic [DATA_W-1:0] i_wb_data,
   output logic [DATA_W-1:0] o_val
);
   import ex_pkg::*;

   logic w_hit;

   // r0 is hard-wired zero, so a writeback naming it never replaces an operand.
   assign w_hit = i_fwd_en & i_wb_valid & (i_wb_rd == i_reg) & (i_reg != REG_W'(REG_ZERO));
   assign o_val = w_hit ? i_wb_data : i_val;

endmodule

// File: rtl/ex_issue_stage.sv
// Two-entry skid buffer between decode and the ALU with writeback snooping of held operands.
// Forwarding (capture snoop, held snoop, output bypass) is built only when EX_ISSUE_FWD_EN is defined.
module ex_issue_stage #(
   parameter int unsigned DATA_W = ex_pkg::DATA_W,
   parameter int unsigned OP_W   = ex_pkg::OP_W,
   parameter int unsigned REG_W  = ex_pkg::REG_W
) (
   input  logic      clk,
   input  logic      rst,
   ex_issue_if.slave bus
);
   import ex_pkg::*;

`ifdef EX_ISSUE_FWD_EN
   localparam logic FWD_EN = 1'b1;
`else
   localparam logic FWD_EN = 1'b0;
`endif

   logic [1:0]        r_count;
   logic              r_head;
   logic              r_tail;
   logic              r_id_ready;

   logic [OP_W-1:0]   r_op      [2];
   logic [REG_W-1:0]  r_rd      [2];
   logic              r_wr_en   [2];
   logic [REG_W-1:0]  r_ra      [2];
   logic [REG_W-1:0]  r_rb      [2];
   logic [DATA_W-1:0] r_a       [2];
   logic [DATA_W-1:0] r_b       [2];
   logic              r_use_imm [2];

   logic [1:0]        w_count_nxt;
   logic              w_push;
   logic              w_pop;
   logic              w_slot_vld [2];
   logic [DATA_W-1:0] w_cap_a;
   logic [DATA_W-1:0] w_cap_b_snp;
   logic [DATA_W-1:0] w_cap_b;
   logic [DATA_W-1:0] w_held_a   [2];
   logic [DATA_W-1:0] w_held_b   [2];

   assign w_push = bus.id_valid & r_id_ready;
   assign w_pop  = (r_count != 2'd0) & bus.ex_ready;

   always_comb begin
      w_count_nxt = r_count;
      if (bus.flush) begin
         w_count_nxt = 2'd0;
      end else if (w_push && !w_pop) begin
         w_count_nxt = r_count + 2'd1;
      end else if (w_pop && !w_push) begin
         w_count_nxt = r_count - 2'd1;
      end
   end

   // The head slot is live with one entry; both are live when full.
   assign w_slot_vld[0] = (r_count == 2'd2) | ((r_count == 2'd1) & (r_head == 1'b0));
   assign w_slot_vld[1] = (r_count == 2'd2) | ((r_count == 2'd1) & (r_head == 1'b1));

   ex_operand_snoop #(.DATA_W(DATA_W), .REG_W(REG_W)) u_cap_a (
      .i_fwd_en   (FWD_EN),
      .i_reg      (bus.id_ra),
      .i_val      (bus.id_a),
      .i_wb_valid (bus.wb_valid),
      .i_wb_rd    (bus.wb_rd),
      .i_wb_data  (bus.wb_data),
      .o_val      (w_cap_a)
   );

   ex_operand_snoop #(.DATA_W(DATA_W), .REG_W(REG_W)) u_cap_b (
      .i_fwd_en   (FWD_EN & ~bus.id_use_imm),
      .i_reg      (bus.id_rb),
      .i_val      (bus.id_b),
      .i_wb_valid (bus.wb_valid),
      .i_wb_rd    (bus.wb_rd),
      .i_wb_data  (bus.wb_data),
      .o_val      (w_cap_b_snp)
   );

   assign w_cap_b = bus.id_use_imm ? bus.id_imm : w_cap_b_snp;

   for (genvar g = 0; g < 2; g++) begin : g_held
      ex_operand_snoop #(.DATA_W(DATA_W), .REG_W(REG_W)) u_held_a (
         .i_fwd_en   (FWD_EN & w_slot_vld[g]),
         .i_reg      (r_ra[g]),
         .i_val      (r_a[g]),
         .i_wb_valid (bus.wb_valid),
         .i_wb_rd    (bus.wb_rd),
         .i_wb_data  (bus.wb_data),
         .o_val      (w_held_a[g])
      );

      ex_operand_snoop #(.DATA_W(DATA_W), .REG_W(REG_W)) u_held_b (
         .i_fwd_en   (FWD_EN & w_slot_vld[g] & ~r_use_imm[g]),
         .i_reg      (r_rb[g]),
         .i_val      (r_b[g]),
         .i_wb_valid (bus.wb_valid),
         .i_wb_rd    (bus.wb_rd),
         .i_wb_data  (bus.wb_data),
         .o_val      (w_held_b[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count    <= 2'd0;
         r_head     <= 1'b0;
         r_tail     <= 1'b0;
         r_id_ready <= 1'b1;
         for (int unsigned i = 0; i < 2; i++) begin
            r_op[i]      <= '0;
            r_rd[i]      <= '0;
            r_wr_en[i]   <= 1'b0;
            r_ra[i]      <= '0;
            r_rb[i]      <= '0;
            r_a[i]       <= '0;
            r_b[i]       <= '0;
            r_use_imm[i] <= 1'b0;
         end
      end else begin
         r_count    <= w_count_nxt;
         r_id_ready <= (w_count_nxt != 2'd2);
         if (bus.flush) begin
            r_head <= 1'b0;
            r_tail <= 1'b0;
         end else begin
            if (w_push) r_tail <= ~r_tail;
            if (w_pop)  r_head <= ~r_head;
         end
         for (int unsigned i = 0; i < 2; i++) begin
            if (w_push && !bus.flush && (r_tail == i[0])) begin
               r_op[i]      <= bus.id_op;
               r_rd[i]      <= bus.id_rd;
               r_wr_en[i]   <= bus.id_wr_en;
               r_ra[i]      <= bus.id_ra;
               r_rb[i]      <= bus.id_rb;
               r_a[i]       <= w_cap_a;
               r_b[i]       <= w_cap_b;
               r_use_imm[i] <= bus.id_use_imm;
            end else begin
               r_a[i] <= w_held_a[i];
               r_b[i] <= w_held_b[i];
            end
         end
      end
   end

   // Output bypass lets a popping instruction see the writeback of its predecessor.
   ex_operand_snoop #(.DATA_W(DATA_W), .REG_W(REG_W)) u_out_a (
      .i_fwd_en   (FWD_EN),
      .i_reg      (r_ra[r_head]),
      .i_val      (r_a[r_head]),
      .i_wb_valid (bus.wb_valid),
      .i_wb_rd    (bus.wb_rd),
      .i_wb_data  (bus.wb_data),
      .o_val      (bus.ex_a)
   );

   ex_operand_snoop #(.DATA_W(DATA_W), .REG_W(REG_W)) u_out_b (
      .i_fwd_en   (FWD_EN & ~r_use_imm[r_head]),
      .i_reg      (r_rb[r_head]),
      .i_val      (r_b[r_head]),
      .i_wb_valid (bus.wb_valid),
      .i_wb_rd    (bus.wb_rd),
      .i_wb_data  (bus.wb_data),
      .o_val      (bus.ex_b)
   );

   assign bus.id_ready = r_id_ready;
   assign bus.ex_valid = (r_count != 2'd0);
   assign bus.ex_op    = r_op[r_head];
   assign bus.ex_rd    = r_rd[r_head];
   assign bus.ex_wr_en = r_wr_en[r_head];

endmodule

// File: tb/tb_ex_issue_stage.sv
// Scoreboard bench for ex_issue_stage; expectations follow EX_ISSUE_FWD_EN like the design.
module tb_ex_issue_stage;
   import ex_pkg::*;

`ifdef EX_ISSUE_FWD_EN
   localparam bit FWD_ON = 1'b1;
`else
   localparam bit FWD_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ex_issue_if bus ();

   ex_issue_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int       n_cmp = 0;
   int       n_err = 0;
   ex_slot_t q[$];
   bit       exp_rdy;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] snp(input logic [2:0] r, input logic [15:0] v);
      if (FWD_ON && bus.wb_valid && (bus.wb_rd == r) && (r != REG_ZERO)) return bus.wb_data;
      return v;
   endfunction

   task automatic drive_id(input logic [3:0] op, input logic [2:0] rd, input logic wr_en,
                           input logic [2:0] ra, input logic [15:0] a,
                           input logic [2:0] rb, input logic [15:0] b,
                           input logic use_imm, input logic [15:0] imm);
      bus.id_valid   = 1'b1;
      bus.id_op      = op;
      bus.id_rd      = rd;
      bus.id_wr_en   = wr_en;
      bus.id_ra      = ra;
      bus.id_a       = a;
      bus.id_rb      = rb;
      bus.id_b       = b;
      bus.id_use_imm = use_imm;
      bus.id_imm     = imm;
   endtask

   // One cycle: compare head against the model, then advance the model with this cycle's inputs.
   task automatic step();
      ex_slot_t h;
      ex_slot_t n;
      @(negedge clk);
      check("id_ready", 32'(bus.id_ready), 32'(exp_rdy));
      check("ex_valid", 32'(bus.ex_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         h = q[0];
         check("ex_op", 32'(bus.ex_op), 32'(h.op));
         check("ex_rd", 32'(bus.ex_rd), 32'(h.rd));
         check("ex_wr_en", 32'(bus.ex_wr_en), 32'(h.wr_en));
         check("ex_a", 32'(bus.ex_a), 32'(snp(h.ra, h.a)));
         check("ex_b", 32'(bus.ex_b), 32'(h.use_imm ? h.b : snp(h.rb, h.b)));
         if (bus.ex_ready) void'(q.pop_front());
      end
      foreach (q[i]) begin
         q[i].a = snp(q[i].ra, q[i].a);
         if (!q[i].use_imm) q[i].b = snp(q[i].rb, q[i].b);
      end
      if (bus.flush) begin
         q.delete();
      end else if (bus.id_valid && exp_rdy) begin
         n.op      = bus.id_op;
         n.rd      = bus.id_rd;
         n.wr_en   = bus.id_wr_en;
         n.ra      = bus.id_ra;
         n.rb      = bus.id_rb;
         n.a       = snp(bus.id_ra, bus.id_a);
         n.b       = bus.id_use_imm ? bus.id_imm : snp(bus.id_rb, bus.id_b);
         n.use_imm = bus.id_use_imm;
         q.push_back(n);
      end
      exp_rdy = (q.size() != 2);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      bus.flush = 1'b0;
      bus.id_valid = 1'b0;
      drive_id(4'h0, 3'd0, 1'b0, 3'd0, 16'h0, 3'd0, 16'h0, 1'b0, 16'h0);
      bus.id_valid = 1'b0;
      bus.wb_valid = 1'b0;
      bus.wb_rd    = 3'd0;
      bus.wb_data  = 16'h0;
      bus.ex_ready = 1'b0;
      exp_rdy      = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
      check("rst_id_ready", 32'(bus.id_ready), 32'd1);
      check("rst_ex_op", 32'(bus.ex_op), 32'd0);
      check("rst_ex_a", 32'(bus.ex_a), 32'd0);
      check("rst_ex_b", 32'(bus.ex_b), 32'd0);
      check("rst_ex_rd", 32'(bus.ex_rd), 32'd0);
      check("rst_ex_wr_en", 32'(bus.ex_wr_en), 32'd0);
      rst = 1'b0;

      // Basic push with a one-cycle visible latency.
      bus.ex_ready = 1'b1;
      drive_id(OP_ADD, 3'd5, 1'b1, 3'd1, 16'h1234, 3'd2, 16'h4321, 1'b0, 16'h0);
      step();
      bus.id_valid = 1'b0;
      check("basic_valid", 32'(bus.ex_valid), 32'd1);
      check("basic_a", 32'(bus.ex_a), 32'h1234);
      check("basic_b", 32'(bus.ex_b), 32'h4321);
      step();
      step();

      // Backpressure until full, then drain in order.
      bus.ex_ready = 1'b0;
      drive_id(OP_SUB, 3'd1, 1'b1, 3'd2, 16'h0011, 3'd3, 16'h0022, 1'b0, 16'h0);
      step();
      drive_id(OP_AND, 3'd2, 1'b0, 3'd4, 16'h0033, 3'd5, 16'h0044, 1'b0, 16'h0);
      step();
      check("full_id_ready", 32'(bus.id_ready), 32'd0);
      drive_id(OP_OR, 3'd3, 1'b1, 3'd6, 16'h0055, 3'd7, 16'h0066, 1'b0, 16'h0);
      step();
      bus.id_valid = 1'b0;
      bus.ex_ready = 1'b1;
      repeat (3) step();

      // Held snoop on an entry stalled by backpressure.
      bus.ex_ready = 1'b0;
      drive_id(OP_ADD, 3'd1, 1'b1, 3'd3, 16'h0000, 3'd0, 16'h0000, 1'b0, 16'h0);
      step();
      bus.id_valid = 1'b0;
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 3'd3;
      bus.wb_data  = 16'hBEEF;
      step();
      bus.wb_valid = 1'b0;
      step();
      check("held_snoop_a", 32'(bus.ex_a), FWD_ON ? 32'hBEEF : 32'h0000);
      bus.ex_ready = 1'b1;
      repeat (2) step();

      // Output bypass to a dependent B operand, then an immediate that must ignore it.
      for (int k = 0; k < 2; k++) begin
         bus.ex_ready = 1'b0;
         drive_id(OP_SUB, 3'd4, 1'b1, 3'd1, 16'h0100, 3'd2, 16'h0001, 1'b0, 16'h0);
         step();
         drive_id((k == 0) ? OP_ADD : OP_SHL, 3'd5, 1'b1, 3'd1, 16'h0003, 3'd4, 16'h1111,
                  (k != 0), 16'h0002);
         step();
         bus.id_valid = 1'b0;
         bus.ex_ready = 1'b1;
         step();
         bus.wb_valid = 1'b1;
         bus.wb_rd    = 3'd4;
         bus.wb_data  = 16'h0BCC;
         #1;
         if (k == 0) check("bypass_b", 32'(bus.ex_b), FWD_ON ? 32'h0BCC : 32'h1111);
         else        check("imm_b", 32'(bus.ex_b), 32'h0002);
         step();
         bus.wb_valid = 1'b0;
         bus.id_use_imm = 1'b0;
      end

      // r0 never matches a writeback.
      bus.ex_ready = 1'b0;
      drive_id(OP_MOV, 3'd2, 1'b1, 3'd0, 16'h5555, 3'd0, 16'h6666, 1'b0, 16'h0);
      step();
      bus.id_valid = 1'b0;
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 3'd0;
      bus.wb_data  = 16'hFFFF;
      step();
      check("r0_a", 32'(bus.ex_a), 32'h5555);
      bus.wb_valid = 1'b0;
      bus.ex_ready = 1'b1;
      step();

      // Flush while full with a push attempt in the same cycle.
      bus.ex_ready = 1'b0;
      drive_id(OP_XOR, 3'd1, 1'b1, 3'd1, 16'hAAAA, 3'd2, 16'hBBBB, 1'b0, 16'h0);
      step();
      drive_id(OP_NOT, 3'd2, 1'b1, 3'd3, 16'hCCCC, 3'd4, 16'hDDDD, 1'b0, 16'h0);
      step();
      bus.flush = 1'b1;
      step();
      bus.flush    = 1'b0;
      bus.id_valid = 1'b0;
      check("flush_ex_valid", 32'(bus.ex_valid), 32'd0);
      check("flush_id_ready", 32'(bus.id_ready), 32'd1);
      step();

      // Random traffic with arbitrary writebacks and occasional flushes.
      for (int c = 0; c < 120; c++) begin
         drive_id(4'($urandom_range(0, 12)), 3'($urandom), 1'($urandom), 3'($urandom),
                  16'($urandom), 3'($urandom), 16'($urandom), 1'($urandom), 16'($urandom));
         bus.id_valid = 1'($urandom);
         bus.ex_ready = 1'($urandom);
         bus.wb_valid = 1'($urandom);
         bus.wb_rd    = 3'($urandom);
         bus.wb_data  = 16'($urandom);
         bus.flush    = ($urandom_range(0, 15) == 0);
         step();
      end
      bus.id_valid = 1'b0;
      bus.wb_valid = 1'b0;
      bus.flush    = 1'b0;
      bus.ex_ready = 1'b1;
      repeat (3) step();
      check("drain_empty", 32'(bus.ex_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
